if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 164 ++++++++++++++++
 tb/tb_if_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage for the 5-stage RV32I core.
//
// Holds the PC and assembles each 32-bit instruction from four little-endian
// bytes read over the shared 8-bit memory port (fixed 1-cycle read latency).
// The assembled instruction is presented to the IF/ID register until decode
// accepts it. EX may redirect the PC at any time, and the memory arbiter may
// take the port away, in which case the current fetch restarts from byte 0.
//
// Ports:
//   clk           in   clock, all state updates on rising edge
//   rst           in   synchronous, active-high reset
//   stall_i       in   downstream not ready; hold presented instruction
//   jump_i        in   redirect request from EX
//   jump_addr_i   in   [31:0] redirect target, bits [1:0] forced to 0
//   mem_grant_i   in   arbiter grants the memory port to IF this cycle
//   mem_din_i     in   [7:0] byte for the address issued in the previous cycle
//   mem_a_o       out  [31:0] byte address to memory
//   mem_rd_o      out  read strobe
//   pc_o          out  [31:0] address of the presented instruction
//   inst_o        out  [31:0] presented instruction, 0 when not valid
//   inst_valid_o  out  inst_o / pc_o valid
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic        mem_rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    // S0..S3 issue byte address pc+0..pc+3; S4 receives the last byte;
    // VALID presents the instruction until it is consumed.
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        S4    = 3'd4,
        VALID = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q,     pc_d;
    logic [23:0] buf_q,    buf_d;     // bytes 2..0 of the instruction in flight
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_q,   inst_d;
    logic        valid_q,  valid_d;
    logic [1:0]  byte_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        mem_rd_o = 1'b0;
        mem_a_o  = 32'h0;
        byte_idx = 2'd0;

        case (state_q)
            S0, S1, S2, S3: begin
                byte_idx = state_q[1:0];
                if (mem_grant_i) begin
                    mem_rd_o = 1'b1;
                    mem_a_o  = pc_q + {30'd0, byte_idx};
                    // Each state captures the byte requested by the previous one.
                    case (state_q)
                        S0: state_d = S1;
                        S1: begin
                            buf_d[7:0] = mem_din_i;
                            state_d    = S2;
                        end
                        S2: begin
                            buf_d[15:8] = mem_din_i;
                            state_d     = S3;
                        end
                        S3: begin
                            buf_d[23:16] = mem_din_i;
                            state_d      = S4;
                        end
                        default: state_d = S0;
                    endcase
                end else begin
                    // Port lost: partial bytes are useless, restart at byte 0.
                    buf_d   = 24'h0;
                    state_d = S0;
                end
            end

            S4: begin
                // Byte 3 arrives now; no request is needed, so grant is ignored.
                inst_d   = {mem_din_i, buf_q};
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                state_d  = VALID;
            end

            VALID: begin
                if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    inst_d  = 32'h0;
                    state_d = S0;
                end
            end

            default: state_d = S0;
        endcase

        // Redirect overrides grant loss and consume; the memory request of
        // this cycle still follows the current state, and S0 ignores the
        // byte that comes back for it.
        if (jump_i) begin
            pc_d    = {jump_addr_i[31:2], 2'b00};
            buf_d   = 24'h0;
            valid_d = 1'b0;
            inst_d  = 32'h0;
            state_d = S0;
        end

        if (rst) begin
            mem_rd_o = 1'b0;
            mem_a_o  = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S0;
            pc_q     <= RESET_PC;
            buf_q    <= 24'h0;
            pc_out_q <= 32'h0;
            inst_q   <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

    assign pc_o         = pc_out_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
// Two instances share stimulus: one with RESET_PC=0, one with RESET_PC at the
// top of the address space so PC wrap-around is exercised. Each has its own
// byte memory model and its own behavioural reference.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             stall;
    logic             jump;
    logic [31:0]      jaddr;
    logic             grant;
    logic [1:0][7:0]  din;
    logic [1:0][31:0] mem_a;
    logic [1:0]       rd;
    logic [1:0][31:0] pc_o;
    logic [1:0][31:0] inst;
    logic [1:0]       vld;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .jump_i       (jump),
        .jump_addr_i  (jaddr),
        .mem_grant_i  (grant),
        .mem_din_i    (din[0]),
        .mem_a_o      (mem_a[0]),
        .mem_rd_o     (rd[0]),
        .pc_o         (pc_o[0]),
        .inst_o       (inst[0]),
        .inst_valid_o (vld[0])
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .jump_i       (jump),
        .jump_addr_i  (jaddr),
        .mem_grant_i  (grant),
        .mem_din_i    (din[1]),
        .mem_a_o      (mem_a[1]),
        .mem_rd_o     (rd[1]),
        .pc_o         (pc_o[1]),
        .inst_o       (inst[1]),
        .inst_valid_o (vld[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: fixed program bytes at 0..3, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'hA0;
            32'd3:   return 8'h00;
            default: begin
                h = a * 32'h9E37_79B1;
                return h[31:24] ^ h[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    function automatic logic [31:0] rpc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    // Reference: pc, number of consecutive granted requests in the current
    // attempt, and the presented instruction.
    logic [31:0] m_pc    [2];
    int          m_got   [2];
    logic        m_valid [2];
    logic [31:0] m_inst  [2];
    logic [31:0] m_pco   [2];
    logic [31:0] iss_a   [2];
    logic        iss_rd  [2];

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pc[i] = rpc(i); m_got[i] = 0; m_valid[i] = 1'b0;
                m_inst[i] = 32'h0; m_pco[i] = 32'h0;
            end else if (jump) begin
                m_pc[i] = {jaddr[31:2], 2'b00}; m_got[i] = 0;
                m_valid[i] = 1'b0; m_inst[i] = 32'h0;
            end else if (m_valid[i]) begin
                if (!stall) begin
                    m_pc[i] = m_pc[i] + 32'd4; m_got[i] = 0;
                    m_valid[i] = 1'b0; m_inst[i] = 32'h0;
                end
            end else if (m_got[i] == 4) begin
                m_valid[i] = 1'b1; m_inst[i] = exp_word(m_pc[i]); m_pco[i] = m_pc[i];
            end else if (grant) begin
                m_got[i] = m_got[i] + 1;
            end else begin
                m_got[i] = 0;
            end
        end
    endtask

    task automatic compare();
        logic        e_rd;
        logic [31:0] e_a;
        for (int i = 0; i < 2; i++) begin
            e_rd = !rst && !m_valid[i] && (m_got[i] < 4) && grant;
            e_a  = e_rd ? m_pc[i] + 32'(m_got[i]) : 32'h0;
            check($sformatf("dut%0d mem_rd", i), {31'd0, rd[i]}, {31'd0, e_rd});
            check($sformatf("dut%0d mem_a", i), mem_a[i], e_a);
            check($sformatf("dut%0d valid", i), {31'd0, vld[i]}, {31'd0, m_valid[i]});
            check($sformatf("dut%0d inst", i), inst[i], m_inst[i]);
            if (m_valid[i])
                check($sformatf("dut%0d pc", i), pc_o[i], m_pco[i]);
            iss_a[i]  = mem_a[i];
            iss_rd[i] = rd[i];
        end
    endtask

    // One clock cycle: advance the model at the edge, drive this cycle's
    // inputs just after it, compare outputs at the falling edge.
    task automatic step(input logic r, input logic s, input logic j,
                        input logic [31:0] ja, input logic g);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; stall = s; jump = j; jaddr = ja; grant = g;
        for (int i = 0; i < 2; i++)
            din[i] = iss_rd[i] ? mem_byte(iss_a[i]) : 8'($urandom);
        @(negedge clk);
        compare();
    endtask

    task automatic go(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic        r, s, j, g;
        logic [31:0] ja;
        rst = 1'b1; stall = 1'b0; jump = 1'b0; jaddr = 32'h0; grant = 1'b1;
        din = '0;
        for (int i = 0; i < 2; i++) begin
            iss_a[i] = 32'h0; iss_rd[i] = 1'b0;
            m_pc[i] = 32'h0; m_got[i] = 0; m_valid[i] = 1'b0;
            m_inst[i] = 32'h0; m_pco[i] = 32'h0;
        end

        // Reset, then the first fetch from address 0.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("first fetch addr", mem_a[0], 32'(k));
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("s4 no read", {31'd0, rd[0]}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("first valid", {31'd0, vld[0]}, 32'd1);
        check("first inst", inst[0], 32'h00A0_0513);
        check("first pc", pc_o[0], 32'h0);
        check("wrap top pc", pc_o[1], 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("next fetch addr", mem_a[0], 32'h4);
        check("wrap next addr", mem_a[1], 32'h0);

        // Stall for three cycles in VALID, then release.
        go(4);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check("stall inst hold", inst[0], exp_word(32'h4));
            check("stall no read", {31'd0, rd[0]}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("release invalid", {31'd0, vld[0]}, 32'd0);
        check("release addr", mem_a[0], 32'h8);

        // Grant lost during S2: restart from pc+0.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("no grant no read", {31'd0, rd[0]}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("restart addr", mem_a[0], 32'h8);
        go(4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("restart valid", {31'd0, vld[0]}, 32'd1);
        check("restart inst", inst[0], exp_word(32'h8));

        // Jump during S3 to an unaligned target.
        go(3);
        step(1'b0, 1'b0, 1'b1, 32'h0000_1002, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("jump addr", mem_a[0], 32'h1000);
        go(4);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        check("jump pc", pc_o[0], 32'h1000);
        check("jump inst", inst[0], exp_word(32'h1000));

        // Jump with stall=0 in VALID beats consume.
        go(5);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
        check("pc 0x40 valid", pc_o[0], 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("jump over consume valid", {31'd0, vld[0]}, 32'd0);
        check("jump over consume addr", mem_a[0], 32'h80);

        // Reset asserted during S2.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst gates read", {31'd0, rd[0]}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst restart top", mem_a[1], 32'hFFFF_FFFC);
        check("rst restart zero", mem_a[0], 32'h0);
        check("rst invalid", {31'd0, vld[1]}, 32'd0);

        // Randomised traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            j  = ($urandom_range(0, 24) == 0);
            ja = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
            g  = ($urandom_range(0, 9) < 8);
            s  = ($urandom_range(0, 9) < 4);
            step(r, s, j, ja, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
